// File: rtl/timer_arbiter.sv
// Round-robin arbiter that grants one requester at a time a
// loadable down-counter interval, with abort and completion pulse.
module timer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*CNT_W-1:0] i_len,
    input  logic                     i_abort,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [NUM_REQ-1:0]       o_done,
    output logic                     o_busy,
    output logic [CNT_W-1:0]         o_cnt_val
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [IDX_W-1:0]   winner, winner_nx;
    logic [IDX_W-1:0]   last, last_nx;
    logic [IDX_W-1:0]   pick;
    logic               found;
    logic [CNT_W-1:0]   len_sel;
    logic [NUM_REQ-1:0] win_oh;

    // Search starts just past the last winner so it rotates to lowest priority
    always_comb begin : search
        int idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!found && i_req[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    assign len_sel = i_len[int'(pick)*CNT_W +: CNT_W];
    assign win_oh  = NUM_REQ'(1) << winner;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        winner_nx = winner;
        last_nx   = last;
        o_gnt     = '0;
        o_done    = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx  = RUN;
                    cnt_nx    = len_sel;
                    winner_nx = pick;
                end
            end
            RUN: begin
                o_gnt = win_oh;
                // Abort wins over expiry: no completion pulse
                if (i_abort) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    last_nx  = winner;
                end else if (cnt == '0) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                o_done   = win_oh;
                last_nx  = winner;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            winner <= '0;
            last   <= IDX_W'(NUM_REQ - 1);
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            winner <= winner_nx;
            last   <= last_nx;
        end
    end

    assign o_busy    = (state != IDLE);
    assign o_cnt_val = cnt;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed vector bench for timer_arbiter (4 requesters, 16-bit count).
module tb_timer_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] len;
    logic        abort;
    logic [3:0]  o_gnt;
    logic [3:0]  o_done;
    logic        o_busy;
    logic [15:0] o_cnt_val;

    int errors = 0;
    int checks = 0;

    timer_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_len    (len),
        .i_abort  (abort),
        .o_gnt    (o_gnt),
        .o_done   (o_done),
        .o_busy   (o_busy),
        .o_cnt_val(o_cnt_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [63:0] len;
        logic        abort;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic [3:0] q, logic [63:0] l,
                               logic a, logic [3:0] g, logic [3:0] d,
                               logic b, logic [15:0] c);
        vec_t t;
        t.rst_n = r; t.req = q; t.len = l; t.abort = a;
        t.gnt = g; t.done = d; t.busy = b; t.cnt = c;
        return t;
    endfunction

    function automatic logic [63:0] lens(logic [15:0] l0, logic [15:0] l1,
                                         logic [15:0] l2, logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic r, logic [3:0] q, logic [63:0] l, logic a);
        @(negedge clk);
        rst_n = r;
        req   = q;
        len   = l;
        abort = a;
    endtask

    task automatic step_check(string nm, logic [3:0] g, logic [3:0] d,
                              logic b, logic [15:0] c);
        @(posedge clk);
        #1;
        check(nm, {7'd0, o_gnt, o_done, o_busy, o_cnt_val},
              {7'd0, g, d, b, c});
    endtask

    initial begin
        int n;
        logic [63:0] l4;
        logic [3:0]  oh;

        rst_n = 1'b0;
        req   = '0;
        len   = '0;
        abort = 1'b0;

        // Single requester, length 3
        tbl.push_back(v(0, 4'b0000, 64'h0, 0, 4'h0, 4'h0, 0, 16'd0));
        tbl.push_back(v(1, 4'b0001, lens(3, 0, 0, 0), 0, 4'h1, 4'h0, 1, 16'd3));
        tbl.push_back(v(1, 4'b0000, lens(7, 9, 9, 9), 0, 4'h1, 4'h0, 1, 16'd2));
        tbl.push_back(v(1, 4'b0000, 64'h0, 0, 4'h1, 4'h0, 1, 16'd1));
        tbl.push_back(v(1, 4'b0000, 64'h0, 0, 4'h1, 4'h0, 1, 16'd0));
        tbl.push_back(v(1, 4'b0000, 64'h0, 0, 4'h0, 4'h1, 1, 16'd0));
        tbl.push_back(v(1, 4'b0000, 64'h0, 0, 4'h0, 4'h0, 0, 16'd0));

        // All requesting, zero lengths: rotation 0,1,2,3,0
        tbl.push_back(v(0, 4'b0000, 64'h0, 0, 4'h0, 4'h0, 0, 16'd0));
        for (int j = 0; j < 5; j++) begin
            oh = 4'b0001 << (j % 4);
            tbl.push_back(v(1, 4'b1111, 64'h0, 0, oh, 4'h0, 1, 16'd0));
            tbl.push_back(v(1, 4'b1111, 64'h0, 0, 4'h0, oh, 1, 16'd0));
            tbl.push_back(v(1, 4'b1111, 64'h0, (j == 1), 4'h0, 4'h0, 0, 16'd0));
        end

        // Abort mid-run, abort at zero count, abort ignored in IDLE
        l4 = lens(0, 0, 10, 2);
        tbl.push_back(v(0, 4'b0000, l4, 0, 4'h0, 4'h0, 0, 16'd0));
        tbl.push_back(v(1, 4'b1100, l4, 0, 4'h4, 4'h0, 1, 16'd10));
        tbl.push_back(v(1, 4'b1100, l4, 0, 4'h4, 4'h0, 1, 16'd9));
        tbl.push_back(v(1, 4'b1000, l4, 0, 4'h4, 4'h0, 1, 16'd8));
        tbl.push_back(v(1, 4'b1100, l4, 0, 4'h4, 4'h0, 1, 16'd7));
        tbl.push_back(v(1, 4'b1100, l4, 1, 4'h0, 4'h0, 0, 16'd0));
        tbl.push_back(v(1, 4'b1100, l4, 0, 4'h8, 4'h0, 1, 16'd2));
        tbl.push_back(v(1, 4'b1100, l4, 0, 4'h8, 4'h0, 1, 16'd1));
        tbl.push_back(v(1, 4'b1100, l4, 0, 4'h8, 4'h0, 1, 16'd0));
        tbl.push_back(v(1, 4'b1100, l4, 1, 4'h0, 4'h0, 0, 16'd0));
        tbl.push_back(v(1, 4'b1100, l4, 1, 4'h4, 4'h0, 1, 16'd10));
        tbl.push_back(v(1, 4'b1100, l4, 1, 4'h0, 4'h0, 0, 16'd0));
        tbl.push_back(v(1, 4'b1000, l4, 0, 4'h8, 4'h0, 1, 16'd2));

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].req, tbl[i].len, tbl[i].abort);
            step_check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].done,
                       tbl[i].busy, tbl[i].cnt);
        end

        // Reset mid-run clears outputs at once and restores priority to 0
        l4 = lens(0, 0, 0, 5);
        drive(0, 4'b0000, l4, 0);
        step_check("d_rst", 4'h0, 4'h0, 0, 16'd0);
        drive(1, 4'b0001, l4, 0);
        step_check("d_g0", 4'h1, 4'h0, 1, 16'd0);
        drive(1, 4'b0000, l4, 0);
        step_check("d_done0", 4'h0, 4'h1, 1, 16'd0);
        drive(1, 4'b0000, l4, 0);
        step_check("d_idle", 4'h0, 4'h0, 0, 16'd0);
        drive(1, 4'b1000, l4, 0);
        step_check("d_g3", 4'h8, 4'h0, 1, 16'd5);
        drive(1, 4'b1000, l4, 0);
        step_check("d_g3run", 4'h8, 4'h0, 1, 16'd4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req   = 4'b1001;
        #1;
        check("d_async", {7'd0, o_gnt, o_done, o_busy, o_cnt_val}, 32'd0);
        drive(1, 4'b1001, l4, 0);
        step_check("d_rearb", 4'h1, 4'h0, 1, 16'd0);

        // Maximum length with the request dropped after one cycle
        drive(0, 4'b0000, 64'h0, 0);
        step_check("e_rst", 4'h0, 4'h0, 0, 16'd0);
        l4 = lens(0, 16'hFFFF, 0, 0);
        drive(1, 4'b0010, l4, 0);
        step_check("e_start", 4'h2, 4'h0, 1, 16'hFFFF);
        drive(1, 4'b0000, l4, 0);
        n = 1;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            #1;
            if (o_gnt == 4'b0010) n++;
            else break;
        end
        check("e_gnt_len", n, 65536);
        check("e_done", {27'd0, o_done, o_busy}, {27'd0, 4'h2, 1'b1});
        @(posedge clk);
        #1;
        check("e_after", {7'd0, o_gnt, o_done, o_busy, o_cnt_val}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the timer; legal range 2..8.
REQ-002 Parameter CNT_W, default 16: width of the load value and down-counter.
REQ-003 Port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port i_req, input, NUM_REQ: per-requester level request for one timed interval.
REQ-006 Port i_len, input, NUM_REQ*CNT_W: per-requester interval length; requester k uses bits [k*CNT_W +: CNT_W].
REQ-007 Port i_abort, input, 1: terminate the running interval without completion.
REQ-008 Port o_gnt, output, NUM_REQ: one-hot grant, high for the whole interval.
REQ-009 Port o_done, output, NUM_REQ: one-hot, single-cycle completion pulse to the granted requester.
REQ-010 Port o_busy, output, 1: high whenever the state is not IDLE.
REQ-011 Port o_cnt_val, output, CNT_W: current down-counter value.

Function
REQ-012 The block SHALL implement exactly three states: IDLE, RUN, DONE.
REQ-013 In IDLE with i_req != 0, the block SHALL pick the first asserted request searching from index (last_winner+1) mod NUM_REQ upward with wrap, latch that requester's i_len into the counter, and enter RUN on the next edge.
REQ-014 In IDLE with i_req == 0, the block SHALL remain in IDLE with all outputs zero.
REQ-015 In RUN, o_gnt SHALL hold the winner's one-hot bit; if counter > 0, it SHALL decrement by 1 per cycle; if counter == 0, the next state SHALL be DONE.
REQ-016 In DONE, o_done SHALL pulse the winner's bit for exactly one cycle, o_gnt SHALL be 0, last_winner SHALL be updated, and the next state SHALL be IDLE.
REQ-017 Latency: a request sampled in IDLE at edge N with length L SHALL produce o_gnt high for cycles N+1..N+L+1 (L+1 cycles) and o_done high in cycle N+L+2.
REQ-018 L = 0 SHALL produce one RUN cycle followed by DONE; the counter SHALL never underflow.
REQ-019 Lengths and requests of non-winners SHALL be ignored during RUN/DONE; there is no preemption.
REQ-020 Deassertion of the winner's i_req during RUN SHALL be ignored; the interval SHALL complete.
REQ-021 i_abort high in RUN SHALL force IDLE on the next edge, with no o_done pulse, counter cleared to 0, and last_winner updated to the aborted requester.
REQ-022 i_abort SHALL be ignored in IDLE and in DONE.
REQ-023 i_abort and counter == 0 in the same RUN cycle SHALL be treated as an abort (no o_done).
REQ-024 A minimum of one IDLE cycle SHALL separate consecutive grants; a requester still asserting after its o_done SHALL be re-eligible with lowest priority.

Reset
REQ-025 Asserting i_rst_n low SHALL immediately force the IDLE state, counter = 0, o_gnt = 0, o_done = 0, o_busy = 0, and last_winner = NUM_REQ-1 (requester 0 highest priority at first arbitration).
REQ-026 Reset mid-RUN SHALL drop the grant without an o_done pulse; arbitration SHALL resume on the first edge after i_rst_n goes high.

Verification
REQ-027 Reset release with i_req=4'b0001, len0=3 -> o_gnt=0001 for 4 cycles, o_cnt_val 3,2,1,0, o_done=0001 for one cycle, then o_busy=0.
REQ-028 i_req=4'b1111 held, all lengths 0 -> grants in the order 0,1,2,3,0, with each grant lasting 1 cycle, followed by a DONE cycle and an IDLE cycle.
REQ-029 req2 granted with len=10, i_abort at cycle 4 of RUN -> IDLE on the next edge, no o_done, next grant goes to 3 if 3 is requesting.
REQ-030 len1=0xFFFF with i_req1 dropped after 1 cycle -> o_gnt stays high for 65536 cycles, then a single o_done pulse.
REQ-031 i_rst_n low for 1 cycle mid-RUN -> all outputs 0 asynchronously, and after release requester 0 wins over requester 3 when both are requesting.
